// File: rtl/bl_pkg.sv
// Shared constants, FSM state type and the global-dimming helper for the zone SPI transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bl_pkg;

  localparam int ZONES     = 360;
  localparam int ZONE_W    = 9;
  localparam int GRAY_W    = 8;
  localparam int DIM_W     = 9;
  localparam int DIM_UNITY = 256;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH
  } state_t;

  // gray * min(dim, unity) >> 8, truncating. With the gain clamped to unity
  // the result never exceeds the input, so it always fits back in GRAY_W bits.
  function automatic logic [GRAY_W-1:0] dim_scale(input logic [GRAY_W-1:0] gray,
                                                  input logic [DIM_W-1:0]  dim);
    logic [DIM_W-1:0]        gain;
    logic [GRAY_W+DIM_W-1:0] prod;
    gain = (dim > DIM_W'(DIM_UNITY)) ? DIM_W'(DIM_UNITY) : dim;
    prod = (GRAY_W + DIM_W)'(gray) * (GRAY_W + DIM_W)'(gain);
    return GRAY_W'(prod >> 8);
  endfunction

endpackage

// File: rtl/bl_zone_dpram.sv
// Ping-pong zone store: two banks of DEPTH gray bytes, one write port, one registered read port.
// Latency: read data appears one clock after the read address; writes land at the clock edge.
// Backpressure: none, both ports accept every cycle.
// Ports: clk; we/wr_bank/wr_addr/wr_dat write port; rd_bank/rd_addr in, rd_dat out (registered).
module bl_zone_dpram
  import bl_pkg::*;
#(
  parameter int DEPTH = 360
) (
  input  logic              clk,
  input  logic              we,
  input  logic              wr_bank,
  input  logic [ZONE_W-1:0] wr_addr,
  input  logic [GRAY_W-1:0] wr_dat,
  input  logic              rd_bank,
  input  logic [ZONE_W-1:0] rd_addr,
  output logic [GRAY_W-1:0] rd_dat
);

  localparam int AW = $clog2(2 * DEPTH);

  logic [GRAY_W-1:0] mem [0:2*DEPTH-1];
  logic [AW-1:0]     wa;
  logic [AW-1:0]     ra;

  // Bank 1 sits directly above bank 0, so the array holds exactly 2*DEPTH entries.
  assign wa = wr_bank ? AW'(DEPTH) + AW'(wr_addr) : AW'(wr_addr);
  assign ra = rd_bank ? AW'(DEPTH) + AW'(rd_addr) : AW'(rd_addr);

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wr_dat;
    end
    rd_dat <= mem[ra];
  end

endmodule

// File: rtl/bl_zone_spi_tx.sv
// Buffers one frame of zone backlight values, then on frame-sync sends them dimmed over SPI mode 0 and pulses the latch.
// Latency: first LOAD cycle one clock after the registered frame-sync edge; frame = ZONES*(16*CLK_DIV+2)+LATCH_W cycles.
// Backpressure: none upstream; a frame edge that arrives while transmitting is dropped and counted in overrun_cnt.
// Ports: i_pix_clk, rst_n; zone_valid/zone_idx/zone_gray write strobe; frame_sync, global_dim;
//        spi_sclk/spi_mosi/spi_cs_n, led_latch link outputs; busy, tx_done, overrun_cnt status.
module bl_zone_spi_tx
  import bl_pkg::*;
#(
  parameter int ZONES   = bl_pkg::ZONES,
  parameter int CLK_DIV = 4,
  parameter int LATCH_W = 8
) (
  input  logic              i_pix_clk,
  input  logic              rst_n,
  input  logic              zone_valid,
  input  logic [ZONE_W-1:0] zone_idx,
  input  logic [GRAY_W-1:0] zone_gray,
  input  logic              frame_sync,
  input  logic [DIM_W-1:0]  global_dim,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              spi_cs_n,
  output logic              led_latch,
  output logic              busy,
  output logic              tx_done,
  output logic [7:0]        overrun_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LAT_W = (LATCH_W > 1) ? $clog2(LATCH_W) : 1;

  state_t            state;
  logic              fs_q;
  logic              fs_prev;
  logic              fs_edge;
  logic              wr_bank;
  logic              wr_dirty;
  logic              wr_ok;
  logic [ZONE_W-1:0] ptr;
  logic              ld_second;
  logic [DIV_W-1:0]  div_cnt;
  logic [2:0]        bit_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [GRAY_W-1:0] shreg;
  logic [GRAY_W-1:0] rd_dat;
  logic [GRAY_W-1:0] scaled;

  assign fs_edge = fs_q & ~fs_prev;
  assign wr_ok   = zone_valid && (int'(zone_idx) < ZONES);
  assign scaled  = dim_scale(rd_dat, global_dim);

  // Writes always target the current write bank; on a swap cycle that is still
  // the pre-swap bank, so a coincident write joins the frame about to be sent.
  // The read bank is simply the other one.
  bl_zone_dpram #(
    .DEPTH (ZONES)
  ) u_ram (
    .clk     (i_pix_clk),
    .we      (wr_ok),
    .wr_bank (wr_bank),
    .wr_addr (zone_idx),
    .wr_dat  (zone_gray),
    .rd_bank (~wr_bank),
    .rd_addr (ptr),
    .rd_dat  (rd_dat)
  );

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fs_q        <= 1'b0;
      fs_prev     <= 1'b0;
      wr_bank     <= 1'b0;
      wr_dirty    <= 1'b0;
      ptr         <= '0;
      ld_second   <= 1'b0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      lat_cnt     <= '0;
      shreg       <= '0;
      spi_sclk    <= 1'b0;
      spi_mosi    <= 1'b0;
      spi_cs_n    <= 1'b1;
      led_latch   <= 1'b0;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      fs_q    <= frame_sync;
      fs_prev <= fs_q;
      tx_done <= 1'b0;

      if (wr_ok) begin
        wr_dirty <= 1'b1;
      end

      if (fs_edge && (state != IDLE) && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end

      case (state)
        IDLE: begin
          if (fs_edge && wr_dirty) begin
            // The swap clears dirty even if a write lands this cycle:
            // that write belongs to the outgoing frame.
            wr_bank   <= ~wr_bank;
            wr_dirty  <= 1'b0;
            ptr       <= '0;
            ld_second <= 1'b0;
            busy      <= 1'b1;
            spi_cs_n  <= 1'b0;
            state     <= LOAD;
          end
        end

        LOAD: begin
          // First cycle presents the address; second cycle has the RAM data.
          if (!ld_second) begin
            ld_second <= 1'b1;
          end else begin
            ld_second <= 1'b0;
            shreg     <= scaled;
            spi_mosi  <= scaled[GRAY_W-1];
            div_cnt   <= '0;
            bit_cnt   <= '0;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (!spi_sclk) begin
              spi_sclk <= 1'b1;
            end else begin
              // End of a high phase closes the current bit.
              spi_sclk <= 1'b0;
              if (bit_cnt == 3'(GRAY_W - 1)) begin
                if (ptr == ZONE_W'(ZONES - 1)) begin
                  spi_cs_n  <= 1'b1;
                  spi_mosi  <= 1'b0;
                  led_latch <= 1'b1;
                  lat_cnt   <= '0;
                  state     <= LATCH;
                end else begin
                  ptr   <= ptr + 1'b1;
                  state <= LOAD;
                end
              end else begin
                bit_cnt  <= bit_cnt + 3'd1;
                shreg    <= {shreg[GRAY_W-2:0], 1'b0};
                spi_mosi <= shreg[GRAY_W-2];
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        LATCH: begin
          if (lat_cnt == LAT_W'(LATCH_W - 1)) begin
            led_latch <= 1'b0;
            busy      <= 1'b0;
            tx_done   <= 1'b1;
            state     <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bl_zone_spi_tx.sv
// Self-checking bench for bl_zone_spi_tx: frame-level reference model plus directed frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_bl_zone_spi_tx;

  localparam int ZN     = 360;
  localparam int CD     = 4;
  localparam int LW     = 8;
  localparam int BYTE_T = 16 * CD + 2;
  localparam int FRAME  = ZN * BYTE_T + LW;

  logic       i_pix_clk  = 1'b0;
  logic       rst_n      = 1'b0;
  logic       zone_valid = 1'b0;
  logic [8:0] zone_idx   = '0;
  logic [7:0] zone_gray  = '0;
  logic       frame_sync = 1'b0;
  logic [8:0] global_dim = 9'd256;
  logic       spi_sclk, spi_mosi, spi_cs_n, led_latch, busy, tx_done;
  logic [7:0] overrun_cnt;

  always #5 i_pix_clk = ~i_pix_clk;

  bl_zone_spi_tx #(.ZONES(ZN), .CLK_DIV(CD), .LATCH_W(LW)) dut (
    .i_pix_clk   (i_pix_clk),
    .rst_n       (rst_n),
    .zone_valid  (zone_valid),
    .zone_idx    (zone_idx),
    .zone_gray   (zone_gray),
    .frame_sync  (frame_sync),
    .global_dim  (global_dim),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_cs_n    (spi_cs_n),
    .led_latch   (led_latch),
    .busy        (busy),
    .tx_done     (tx_done),
    .overrun_cnt (overrun_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // ---------------- reference model (frame level) ----------------
  logic [7:0] m_bank [2][ZN];
  logic [7:0] m_byte [ZN];
  int m_wb = 0, m_dirty = 0, m_fs1 = 0, m_fs2 = 0, m_ovr = 0, m_started = 0, m_t0 = 0;

  initial begin
    forever begin
      @(posedge i_pix_clk);
      cyc++;
      if (!rst_n) begin
        m_wb = 0; m_dirty = 0; m_fs1 = 0; m_fs2 = 0; m_ovr = 0; m_started = 0;
      end else begin
        int edge_seen, was_busy, rb, gain;
        edge_seen = (m_fs1 == 1) && (m_fs2 == 0);
        was_busy  = m_started && (cyc - 1 >= m_t0) && (cyc - 1 < m_t0 + FRAME);
        if (zone_valid && int'(zone_idx) < ZN) begin
          m_bank[m_wb][zone_idx] = zone_gray;
          m_dirty = 1;
        end
        if (edge_seen) begin
          if (was_busy) begin
            if (m_ovr < 255) m_ovr++;
          end else if (m_dirty) begin
            rb = m_wb;
            m_wb = 1 - m_wb;
            m_dirty = 0;
            m_started = 1;
            m_t0 = cyc;
            gain = (int'(global_dim) > 256) ? 256 : int'(global_dim);
            for (int z = 0; z < ZN; z++) m_byte[z] = 8'((int'(m_bank[rb][z]) * gain) / 256);
          end
        end
        m_fs2 = m_fs1;
        m_fs1 = int'(frame_sync);
      end
    end
  end

  // ---------------- per-cycle compare + link monitors ----------------
  int busy_cnt = 0, csn_cnt = 0, latch_cnt = 0, busy_seen = 0, start_cyc = 0, done_cyc = 0;
  int cap_n = 0, bits = 0;
  logic [7:0] cap [ZN];
  logic [7:0] sh = '0;
  logic busy_q = 1'b0, csn_q = 1'b1, sclk_q = 1'b0;

  initial begin
    forever begin
      logic e_sclk, e_mosi, e_cs, e_lat, e_busy, e_done, chk_m;
      int e_ovr, t, z, r, s;
      @(negedge i_pix_clk);
      e_sclk = 0; e_mosi = 0; e_cs = 1; e_lat = 0; e_busy = 0; e_done = 0; chk_m = 0;
      e_ovr = rst_n ? m_ovr : 0;
      if (rst_n && m_started && cyc >= m_t0) begin
        t = cyc - m_t0;
        if (t < ZN * BYTE_T) begin
          e_cs = 0; e_busy = 1;
          z = t / BYTE_T; r = t % BYTE_T;
          if (r >= 2) begin
            s = r - 2;
            e_sclk = ((s / CD) % 2) == 1;
            e_mosi = m_byte[z][7 - s / (2 * CD)];
            chk_m = 1;
          end
        end else if (t < ZN * BYTE_T + LW) begin
          e_busy = 1; e_lat = 1;
        end else if (t == FRAME) begin
          e_done = 1;
        end
      end
      n_cmp++;
      if ({spi_sclk, spi_cs_n, led_latch, busy, tx_done} !== {e_sclk, e_cs, e_lat, e_busy, e_done} ||
          overrun_cnt !== 8'(e_ovr) || (chk_m && spi_mosi !== e_mosi)) begin
        n_err++;
        $display("FAIL cycle_outputs @cyc %0d: got sclk=%b mosi=%b cs_n=%b latch=%b busy=%b done=%b ovr=%0d, want sclk=%b mosi=%b(chk=%b) cs_n=%b latch=%b busy=%b done=%b ovr=%0d",
                 cyc, spi_sclk, spi_mosi, spi_cs_n, led_latch, busy, tx_done, overrun_cnt,
                 e_sclk, e_mosi, chk_m, e_cs, e_lat, e_busy, e_done, e_ovr);
      end
      if (rst_n) begin
        if (busy) begin busy_cnt++; busy_seen = 1; end
        if (!spi_cs_n) csn_cnt++;
        if (led_latch) latch_cnt++;
        if (busy && !busy_q) start_cyc = cyc;
        if (tx_done) done_cyc = cyc;
        if (!spi_cs_n && csn_q) begin cap_n = 0; bits = 0; end
        if (!spi_cs_n && spi_sclk && !sclk_q) begin
          sh = {sh[6:0], spi_mosi};
          bits++;
          if (bits == 8) begin
            if (cap_n < ZN) cap[cap_n] = sh;
            cap_n++;
            bits = 0;
          end
        end
      end else begin
        bits = 0;
      end
      busy_q = busy; csn_q = spi_cs_n; sclk_q = spi_sclk;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_pix_clk);
  endtask

  task automatic wr(input int idx, input int g);
    zone_valid = 1'b1;
    zone_idx   = 9'(idx);
    zone_gray  = 8'(g);
    @(negedge i_pix_clk);
    zone_valid = 1'b0;
  endtask

  task automatic fs_pulse();
    frame_sync = 1'b1;
    tick(3);
    frame_sync = 1'b0;
  endtask

  task automatic clr_meas();
    busy_cnt = 0; csn_cnt = 0; latch_cnt = 0; busy_seen = 0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (k < FRAME + 100 && tx_done !== 1'b1) begin
      @(negedge i_pix_clk);
      k++;
    end
    chk(name, 32'(k < FRAME + 100), 1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    tick(4);
    chk("reset_cs_n", 32'(spi_cs_n), 1);
    chk("reset_sclk", 32'(spi_sclk), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_latch", 32'(led_latch), 0);
    chk("reset_overrun", 32'(overrun_cnt), 0);
    rst_n = 1'b1;
    tick(3);

    // Only out-of-range writes: the edge must not start anything.
    clr_meas();
    wr(360, 8'h11);
    wr(511, 8'h22);
    fs_pulse();
    tick(100);
    chk("oob_write_no_busy", 32'(busy_seen), 0);
    chk("oob_write_no_cs", 32'(csn_cnt), 0);

    // Frame A: gray = idx[7:0], unity gain, zone 5 overwritten.
    wr(5, 8'hAA);
    for (int z = 0; z < ZN; z++) wr(z, z & 255);
    clr_meas();
    fs_pulse();
    // Frame B data accumulates while A is on the wire.
    for (int z = 0; z < ZN - 1; z++) wr(z, (z == 0) ? 200 : ((z * 3) & 255));
    tick(1000 - 3 - (ZN - 1));
    fs_pulse();
    wait_done("frame_a_done");
    tick(2);
    chk("frame_a_len", 32'(done_cyc - start_cyc), 23768);
    chk("frame_a_busy_cycles", 32'(busy_cnt), 23768);
    chk("frame_a_cs_low_cycles", 32'(csn_cnt), 23760);
    chk("frame_a_latch_cycles", 32'(latch_cnt), 8);
    chk("frame_a_bytes", 32'(cap_n), 360);
    chk("frame_a_byte5_overwrite", 32'(cap[5]), 5);
    chk("frame_a_byte255", 32'(cap[255]), 255);
    chk("frame_a_byte300", 32'(cap[300]), 44);
    chk("overrun_after_a", 32'(overrun_cnt), 1);

    // Frame B: gain 128, zone 359 written in the swap cycle itself.
    global_dim = 9'd128;
    clr_meas();
    frame_sync = 1'b1;
    tick(1);
    wr(359, 8'h80);
    tick(2);
    frame_sync = 1'b0;
    wait_done("frame_b_done");
    tick(2);
    chk("frame_b_byte0", 32'(cap[0]), 100);
    chk("frame_b_byte10", 32'(cap[10]), 15);
    chk("frame_b_byte359_swap_write", 32'(cap[359]), 64);
    chk("frame_b_len", 32'(done_cyc - start_cyc), 23768);

    // Frame C: gain above unity clamps; reset hits in zone 100.
    global_dim = 9'd300;
    for (int z = 0; z < ZN; z++) wr(z, 255 - (z & 255));
    fs_pulse();
    chk("frame_c_started", 32'(busy), 1);
    tick(100 * BYTE_T + 20);
    chk("frame_c_bytes_before_reset", 32'(cap_n), 100);
    chk("frame_c_byte0", 32'(cap[0]), 255);
    chk("frame_c_byte99", 32'(cap[99]), 156);
    chk("pre_reset_cs_n", 32'(spi_cs_n), 0);
    @(posedge i_pix_clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_cs_n", 32'(spi_cs_n), 1);
    chk("mid_reset_sclk", 32'(spi_sclk), 0);
    chk("mid_reset_busy", 32'(busy), 0);
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // After reset nothing is dirty, so an edge starts nothing.
    clr_meas();
    fs_pulse();
    tick(200);
    chk("post_reset_idle_busy", 32'(busy_seen), 0);
    chk("post_reset_overrun", 32'(overrun_cnt), 0);

    // A fresh dirty frame starts again (bank 0 still holds frame C data).
    wr(7, 8'h33);
    fs_pulse();
    tick(10 * BYTE_T);
    chk("post_reset_bytes", 32'(cap_n), 10);
    chk("post_reset_byte0", 32'(cap[0]), 255);
    chk("post_reset_byte7", 32'(cap[7]), 8'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
